// File: rtl/player_jump_ctrl_if.sv
// ----------------------------------------------------------------------------
// player_jump_ctrl_if
//   Bundles the player controller's control inputs (physics tick and the three
//   buttons) with its registered position and status outputs.
//
//   master : the game side; drives tick/buttons, reads position and status
//   slave  : the controller; reads tick/buttons, drives position and status
//
//   Signals
//     tick        physics strobe, 1-cycle pulse
//     btn_jump    jump button level, already synchronised
//     btn_left    walk-left level
//     btn_right   walk-right level
//     x_player    player x (COORD_W bits)
//     y_player    player y (COORD_W bits), y grows downward
//     state_o     0=GROUND 1=RISE 2=FALL
//     airborne    state_o != GROUND
//     land_pulse  1-cycle pulse following the tick that lands
// ----------------------------------------------------------------------------
interface player_jump_ctrl_if #(
  parameter int COORD_W = 16
);
  logic               tick;
  logic               btn_jump;
  logic               btn_left;
  logic               btn_right;
  logic [COORD_W-1:0] x_player;
  logic [COORD_W-1:0] y_player;
  logic [1:0]         state_o;
  logic               airborne;
  logic               land_pulse;

  modport master (
    output tick, btn_jump, btn_left, btn_right,
    input  x_player, y_player, state_o, airborne, land_pulse
  );

  modport slave (
    input  tick, btn_jump, btn_left, btn_right,
    output x_player, y_player, state_o, airborne, land_pulse
  );
endinterface

// File: rtl/player_jump_ctrl.sv
// ----------------------------------------------------------------------------
// player_jump_ctrl
//   Player motion controller for the VGA game. Vertical motion is a gravity
//   driven jump (unsigned velocity magnitude integrated once per tick),
//   horizontal motion is a fixed-step walk clamped to [X_MIN, X_MAX]. Jump
//   button rising edges are captured every clock and serviced by the next
//   physics tick. Screen coordinates: y grows downward, GROUND_Y is the floor,
//   CEIL_Y the highest reachable y.
//
//   Ports
//     clk    in   system clock
//     reset  in   synchronous, active-high reset
//     bus    player_jump_ctrl_if.slave
//              tick, btn_jump, btn_left, btn_right  (in)
//              x_player, y_player, state_o, airborne, land_pulse  (out)
//
//   Build option
//     PLAYER_DOUBLE_JUMP_EN  when defined, one extra jump is allowed per
//                            airtime; otherwise airborne jump requests are
//                            dropped at the tick that sees them.
// ----------------------------------------------------------------------------
module player_jump_ctrl #(
  parameter int COORD_W  = 16,
  parameter int VEL_W    = 8,
  parameter int X_INIT   = 300,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 620,
  parameter int X_STEP   = 2,
  parameter int GROUND_Y = 400,
  parameter int CEIL_Y   = 50,
  parameter int JUMP_V   = 8,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 12
) (
  input  logic               clk,
  input  logic               reset,
  player_jump_ctrl_if.slave  bus
);

  // Position arithmetic is done one bit wider than the coordinate so sums and
  // differences can be compared before they are truncated back.
  localparam int EW = COORD_W + 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [EW-1:0]      ext_t;
  typedef logic [VEL_W-1:0]   vel_t;
  typedef logic [VEL_W:0]     vel1_t;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam ext_t  X_MIN_E    = ext_t'(X_MIN);
  localparam ext_t  X_MAX_E    = ext_t'(X_MAX);
  localparam ext_t  X_STEP_E   = ext_t'(X_STEP);
  localparam ext_t  GROUND_E   = ext_t'(GROUND_Y);
  localparam ext_t  CEIL_E     = ext_t'(CEIL_Y);
  localparam vel_t  JUMP_VV    = vel_t'(JUMP_V);
  localparam vel_t  GRAVITY_V  = vel_t'(GRAVITY);
  localparam vel1_t GRAVITY_V1 = vel1_t'(GRAVITY);
  localparam vel1_t V_MAX_V1   = vel1_t'(V_MAX);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t state_reg, state_next;
  coord_t x_reg, x_next;
  coord_t y_reg, y_next;
  vel_t   vy_reg, vy_next;
  logic   land_reg, land_next;
  logic   jump_req_reg, jump_req_next;
  logic   btn_q_reg;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic   dj_used_reg, dj_used_next;
`endif

  // --------------------------------------------------------------------------
  // Jump request capture
  // A rising edge arms jump_req; pend also includes the edge of this very
  // cycle so an edge coinciding with a tick is serviced by that tick.
  // --------------------------------------------------------------------------
  logic jump_edge;
  logic pend;

  assign jump_edge = bus.btn_jump & ~btn_q_reg;
  assign pend      = jump_req_reg | jump_edge;

  // --------------------------------------------------------------------------
  // Candidate results for the horizontal walk and the two airborne phases
  // --------------------------------------------------------------------------
  coord_t x_walk;
  ext_t   x_ext;
  ext_t   y_ext;
  ext_t   vy_ext;
  logic   ceil_hit;
  coord_t y_up;
  vel1_t  v_sum;
  vel_t   v_fall;
  ext_t   y_down_ext;
  logic   ground_hit;

  always_comb begin
    x_ext  = ext_t'(x_reg);
    y_ext  = ext_t'(y_reg);
    vy_ext = ext_t'(vy_reg);

    // Walk: opposing buttons cancel; clamps are checked in the wide domain
    // so a step past either edge can never wrap.
    x_walk = x_reg;
    if (bus.btn_left && !bus.btn_right) begin
      if (x_ext < X_MIN_E + X_STEP_E) begin
        x_walk = coord_t'(X_MIN_E);
      end else begin
        x_walk = coord_t'(x_ext - X_STEP_E);
      end
    end else if (bus.btn_right && !bus.btn_left) begin
      if (x_ext + X_STEP_E > X_MAX_E) begin
        x_walk = coord_t'(X_MAX_E);
      end else begin
        x_walk = coord_t'(x_ext + X_STEP_E);
      end
    end

    // Rise: y - vy <= CEIL_Y is rewritten as y <= CEIL_Y + vy, which cannot
    // underflow even when vy exceeds y.
    ceil_hit = (y_ext <= CEIL_E + vy_ext);
    y_up     = coord_t'(y_ext - vy_ext);

    // Fall: accelerate, saturate at terminal speed, then test for the floor.
    v_sum      = vel1_t'(vy_reg) + GRAVITY_V1;
    v_fall     = (v_sum > V_MAX_V1) ? vel_t'(V_MAX_V1) : vel_t'(v_sum);
    y_down_ext = y_ext + ext_t'(v_fall);
    ground_hit = (y_down_ext >= GROUND_E);
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // Nothing moves between ticks; a tick always consumes the pending request.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    vy_next       = vy_reg;
    land_next     = 1'b0;
    jump_req_next = pend;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_used_next  = dj_used_reg;
`endif

    if (bus.tick) begin
      jump_req_next = 1'b0;
      x_next        = x_walk;

      unique case (state_reg)
        ST_GROUND: begin
          if (pend) begin
            // Launch: velocity is loaded now, y starts moving next tick.
            state_next = ST_RISE;
            vy_next    = JUMP_VV;
          end else begin
            y_next  = coord_t'(GROUND_E);
            vy_next = '0;
          end
        end

        ST_RISE: begin
          if (ceil_hit) begin
            y_next     = coord_t'(CEIL_E);
            vy_next    = '0;
            state_next = ST_FALL;
          end else begin
            y_next = y_up;
            if (vy_reg <= GRAVITY_V) begin
              vy_next    = '0;
              state_next = ST_FALL;
            end else begin
              vy_next = vy_reg - GRAVITY_V;
            end
          end
        end

        ST_FALL: begin
          if (ground_hit) begin
            y_next     = coord_t'(GROUND_E);
            vy_next    = '0;
            state_next = ST_GROUND;
            land_next  = 1'b1;
          end else begin
            y_next  = coord_t'(y_down_ext);
            vy_next = v_fall;
          end
        end

        default: begin
          // Unused encoding: put the player back on the floor.
          state_next = ST_GROUND;
          y_next     = coord_t'(GROUND_E);
          vy_next    = '0;
        end
      endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
      // A second launch in mid-air overrides the normal airborne step; the
      // walk still applies on the same tick.
      if (pend && !dj_used_reg &&
          (state_reg == ST_RISE || state_reg == ST_FALL)) begin
        state_next   = ST_RISE;
        vy_next      = JUMP_VV;
        y_next       = y_reg;
        land_next    = 1'b0;
        dj_used_next = 1'b1;
      end
      if (land_next) begin
        dj_used_next = 1'b0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_GROUND;
      x_reg        <= coord_t'(X_INIT);
      y_reg        <= coord_t'(GROUND_E);
      vy_reg       <= '0;
      land_reg     <= 1'b0;
      jump_req_reg <= 1'b0;
      btn_q_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      vy_reg       <= vy_next;
      land_reg     <= land_next;
      jump_req_reg <= jump_req_next;
      btn_q_reg    <= bus.btn_jump;
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dj_used_reg <= 1'b0;
    end else begin
      dj_used_reg <= dj_used_next;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.x_player   = x_reg;
  assign bus.y_player   = y_reg;
  assign bus.state_o    = state_reg;
  assign bus.airborne   = (state_reg != ST_GROUND);
  assign bus.land_pulse = land_reg;

endmodule

// File: tb/tb_player_jump_ctrl.sv
// ----------------------------------------------------------------------------
// tb_player_jump_ctrl
//   Two controllers share one stimulus: dut_a with default parameters and
//   dut_c with JUMP_V=40 (reaches the ceiling) and X_INIT=1 (left clamp).
//   Each is shadowed by a reference model stepped on every clock edge.
// ----------------------------------------------------------------------------
module tb_player_jump_ctrl;

  localparam int GROUND_Y = 400;
  localparam int CEIL_Y   = 50;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 620;
  localparam int X_STEP   = 2;
  localparam int GRAVITY  = 1;
  localparam int V_MAX    = 12;
`ifdef PLAYER_DOUBLE_JUMP_EN
  localparam bit DJ_EN = 1'b1;
`else
  localparam bit DJ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tick_s, bj, bl, br;

  player_jump_ctrl_if #(.COORD_W(16)) bus_a ();
  player_jump_ctrl_if #(.COORD_W(16)) bus_c ();

  assign bus_a.tick      = tick_s;
  assign bus_a.btn_jump  = bj;
  assign bus_a.btn_left  = bl;
  assign bus_a.btn_right = br;
  assign bus_c.tick      = tick_s;
  assign bus_c.btn_jump  = bj;
  assign bus_c.btn_left  = bl;
  assign bus_c.btn_right = br;

  player_jump_ctrl dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  player_jump_ctrl #(.JUMP_V(40), .X_INIT(1)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c)
  );

  // --------------------------------------------------------------------------
  // Reference model: integer physics straight from the motion rules
  // --------------------------------------------------------------------------
  typedef struct packed {
    int x;
    int y;
    int v;
    int st;
    bit land;
    bit req;
    bit q;
    bit dj;
  } model_t;

  function automatic model_t step(model_t m, int jv, int xi,
                                  bit rst, bit tk, bit j, bit l, bit r);
    model_t n;
    bit     pend;
    int     vp;
    if (rst) begin
      n = '0;
      n.x = xi;
      n.y = GROUND_Y;
      return n;
    end
    n      = m;
    n.land = 1'b0;
    n.q    = j;
    pend   = m.req | (j & ~m.q);
    if (!tk) begin
      n.req = pend;
      return n;
    end
    n.req = 1'b0;
    if (l && !r)      n.x = (m.x - X_STEP < X_MIN) ? X_MIN : m.x - X_STEP;
    else if (r && !l) n.x = (m.x + X_STEP > X_MAX) ? X_MAX : m.x + X_STEP;
    if (m.st == 0) begin
      if (pend) begin
        n.st = 1;
        n.v  = jv;
      end
    end else if (pend && DJ_EN && !m.dj) begin
      n.st = 1;
      n.v  = jv;
      n.dj = 1'b1;
    end else if (m.st == 1) begin
      if (m.y - m.v <= CEIL_Y) begin
        n.y = CEIL_Y; n.v = 0; n.st = 2;
      end else begin
        n.y = m.y - m.v;
        if (m.v <= GRAVITY) begin n.v = 0; n.st = 2; end
        else n.v = m.v - GRAVITY;
      end
    end else begin
      vp = (m.v + GRAVITY > V_MAX) ? V_MAX : m.v + GRAVITY;
      if (m.y + vp >= GROUND_Y) begin
        n.y = GROUND_Y; n.v = 0; n.st = 0; n.land = 1'b1; n.dj = 1'b0;
      end else begin
        n.y = m.y + vp; n.v = vp;
      end
    end
    return n;
  endfunction

  model_t ma, mc;
  initial begin
    ma = '0;
    mc = '0;
  end

  always @(posedge clk) begin
    ma <= step(ma, 8,  300, reset, tick_s, bj, bl, br);
    mc <= step(mc, 40, 1,   reset, tick_s, bj, bl, br);
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.x",    32'(bus_a.x_player),   ma.x);
    chk("a.y",    32'(bus_a.y_player),   ma.y);
    chk("a.st",   32'(bus_a.state_o),    ma.st);
    chk("a.air",  32'(bus_a.airborne),   32'(ma.st != 0));
    chk("a.land", 32'(bus_a.land_pulse), 32'(ma.land));
    chk("c.x",    32'(bus_c.x_player),   mc.x);
    chk("c.y",    32'(bus_c.y_player),   mc.y);
    chk("c.st",   32'(bus_c.state_o),    mc.st);
    chk("c.air",  32'(bus_c.airborne),   32'(mc.st != 0));
    chk("c.land", 32'(bus_c.land_pulse), 32'(mc.land));
  endtask

  // One clock: apply inputs, let the edge pass, compare against the models.
  task automatic cyc(input bit t, input bit j, input bit l, input bit r);
    tick_s = t; bj = j; bl = l; br = r;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // --------------------------------------------------------------------------
  // Single-jump table: one row per tick, button held throughout
  // --------------------------------------------------------------------------
  typedef struct {
    bit jump;
    int ay;
    int ast;
    bit aland;
    int cy;
    int cst;
  } vec_t;

  vec_t t2 [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit landed;
    bit reached;

    t2[0]  = '{1, 400, 1, 0, 400, 1};
    t2[1]  = '{1, 392, 1, 0, 360, 1};
    t2[2]  = '{1, 385, 1, 0, 321, 1};
    t2[3]  = '{1, 379, 1, 0, 283, 1};
    t2[4]  = '{1, 374, 1, 0, 246, 1};
    t2[5]  = '{1, 370, 1, 0, 210, 1};
    t2[6]  = '{1, 367, 1, 0, 175, 1};
    t2[7]  = '{1, 365, 1, 0, 141, 1};
    t2[8]  = '{1, 364, 2, 0, 108, 1};
    t2[9]  = '{1, 365, 2, 0,  76, 1};
    t2[10] = '{1, 367, 2, 0,  50, 2};
    t2[11] = '{1, 370, 2, 0,  51, 2};
    t2[12] = '{1, 374, 2, 0,  53, 2};
    t2[13] = '{1, 379, 2, 0,  56, 2};
    t2[14] = '{1, 385, 2, 0,  60, 2};
    t2[15] = '{1, 392, 2, 0,  65, 2};
    t2[16] = '{1, 400, 0, 1,  71, 2};
    t2[17] = '{1, 400, 0, 0,  78, 2};
    t2[18] = '{1, 400, 0, 0,  86, 2};

    // Reset and reset state
    reset = 1'b1; tick_s = 0; bj = 0; bl = 0; br = 0;
    repeat (3) cyc(0, 0, 0, 0);
    chk("rst.a.x",    32'(bus_a.x_player),   300);
    chk("rst.a.y",    32'(bus_a.y_player),   400);
    chk("rst.a.st",   32'(bus_a.state_o),    0);
    chk("rst.a.land", 32'(bus_a.land_pulse), 0);
    chk("rst.c.x",    32'(bus_c.x_player),   1);
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    // Single jump; the edge arrives on the first tick cycle itself
    for (int i = 0; i < 19; i++) begin
      cyc(1, t2[i].jump, 0, 0);
      chk($sformatf("t2.a.y[%0d]", i + 1),    32'(bus_a.y_player),   t2[i].ay);
      chk($sformatf("t2.a.st[%0d]", i + 1),   32'(bus_a.state_o),    t2[i].ast);
      chk($sformatf("t2.a.land[%0d]", i + 1), 32'(bus_a.land_pulse), 32'(t2[i].aland));
      chk($sformatf("t2.c.y[%0d]", i + 1),    32'(bus_c.y_player),   t2[i].cy);
      chk($sformatf("t2.c.st[%0d]", i + 1),   32'(bus_c.state_o),    t2[i].cst);
      cyc(0, t2[i].jump, 0, 0);
      chk("t2.a.land_idle", 32'(bus_a.land_pulse), 0);
    end
    cyc(0, 0, 0, 0);

    // Edge five clocks ahead of the tick is remembered until that tick
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t5.a.st_launch", 32'(bus_a.state_o),  1);
    chk("t5.a.y_launch",  32'(bus_a.y_player), 400);

    // Airborne edge: dropped without double jump; ground afterwards either way
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    landed = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc(1, 0, 0, 0);
      if (bus_a.land_pulse) begin
        landed = 1'b1;
        break;
      end
    end
    chk("t5.a.landed", 32'(landed), 1);
    repeat (3) cyc(1, 0, 0, 0);
    chk("t5.a.st_after", 32'(bus_a.state_o), 0);
    repeat (30) cyc(1, 0, 0, 0);

    // Walk: left clamp on dut_c, right clamp on dut_a, then both/neither
    cyc(1, 0, 1, 0);
    chk("t4.c.x_left1", 32'(bus_c.x_player), 0);
    chk("t4.a.x_left1", 32'(bus_a.x_player), 298);
    cyc(1, 0, 1, 0);
    chk("t4.c.x_left2", 32'(bus_c.x_player), 0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1, 0, 0, 1);
      if (bus_a.x_player == 16'd618) begin
        reached = 1'b1;
        break;
      end
    end
    chk("t4.a.reach618", 32'(reached), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      chk($sformatf("t4.a.x_right[%0d]", i), 32'(bus_a.x_player), 620);
    end
    cyc(1, 0, 1, 0);
    chk("t4.a.x_back", 32'(bus_a.x_player), 618);
    cyc(1, 0, 1, 1);
    chk("t4.a.x_both", 32'(bus_a.x_player), 618);
    cyc(1, 0, 0, 0);
    chk("t4.a.x_none", 32'(bus_a.x_player), 618);

    // Reset during FALL with a pending edge: everything returns to reset values
    cyc(1, 1, 0, 0);
    repeat (9) cyc(1, 0, 0, 0);
    chk("t1.a.st_fall", 32'(bus_a.state_o), 2);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    chk("t1.a.x",    32'(bus_a.x_player),   300);
    chk("t1.a.y",    32'(bus_a.y_player),   400);
    chk("t1.a.st",   32'(bus_a.state_o),    0);
    chk("t1.a.land", 32'(bus_a.land_pulse), 0);
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    chk("t1.a.no_pending", 32'(bus_a.state_o), 0);
    repeat (40) cyc(1, 0, 0, 0);

`ifdef PLAYER_DOUBLE_JUMP_EN
    // Double jump at the apex, third edge ignored, fresh launch after landing
    cyc(1, 1, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);
    chk("t6.a.apex_y",  32'(bus_a.y_player), 364);
    chk("t6.a.apex_st", 32'(bus_a.state_o),  2);
    cyc(1, 1, 0, 0);
    chk("t6.a.dj_st", 32'(bus_a.state_o),  1);
    chk("t6.a.dj_y",  32'(bus_a.y_player), 364);
    cyc(1, 0, 0, 0);
    chk("t6.a.dj_y2", 32'(bus_a.y_player), 356);
    cyc(1, 1, 0, 0);
    chk("t6.a.third_st", 32'(bus_a.state_o),  1);
    chk("t6.a.third_y",  32'(bus_a.y_player), 349);
    landed = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc(1, 0, 0, 0);
      if (bus_a.land_pulse) begin
        landed = 1'b1;
        break;
      end
    end
    chk("t6.a.landed", 32'(landed), 1);
    cyc(1, 1, 0, 0);
    chk("t6.a.relaunch", 32'(bus_a.state_o), 1);
    repeat (60) cyc(1, 0, 0, 0);
`endif

    // Randomised traffic against the models
    for (int i = 0; i < 3000; i++) begin
      logic t, j, l, r;
      reset = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 5) == 0) ? ~bj : bj;
      l = ($urandom_range(0, 9) == 0) ? ~bl : bl;
      r = ($urandom_range(0, 9) == 0) ? ~br : br;
      cyc(t, j, l, r);
    end
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
